// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer. Takes a UART byte
// stream (4-byte little-endian word count, N data words, XOR checksum),
// writes the words to consecutive word addresses from 0, and releases the
// CPU core from reset only after a load with a matching checksum.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic              RxValid,
  input  logic [7:0]        RxData,
  output logic              WE,
  output logic [ADDR_W-1:0] WAddr,
  output logic [31:0]       WData,
  output logic              CpuRstN,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  localparam logic [32:0] MAX_N = 33'(2**ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;   // one extra bit so N = 2**ADDR_W fits
  logic [31:0]       len_q, len_d;
  logic [7:0]        chk_q, chk_d;
  logic [23:0]       asm_q, asm_d;             // low three bytes of the word in progress
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_rst_n_q, busy_q, done_q, error_q;
  logic [31:0]       len_full;
  logic [31:0]       words_written;

  // Register the FSM state, datapath and all outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      word_idx_q  <= '0;
      len_q       <= '0;
      chk_q       <= '0;
      asm_q       <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed by the combinational block.
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_idx_q  <= word_idx_d;
      len_q       <= len_d;
      chk_q       <= chk_d;
      asm_q       <= asm_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      cpu_rst_n_q <= (state_d == S_DONE);
      busy_q      <= (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CHK);
      done_q      <= (state_d == S_DONE);
      error_q     <= (state_d == S_ERR);
    end
  end

  // Next-state and datapath: one received byte is consumed per cycle.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    len_d      = len_q;
    chk_d      = chk_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    len_full      = {RxData, len_q[23:0]};
    words_written = 32'(word_idx_q) + 32'd1;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        // Start takes priority; any byte arriving with it is dropped.
        if (Start) begin
          state_d    = S_LEN;
          byte_cnt_d = '0;
          word_idx_d = '0;
          chk_d      = '0;
        end
      end

      S_LEN: begin
        if (RxValid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: len_d[7:0]   = RxData;
            2'd1: len_d[15:8]  = RxData;
            2'd2: len_d[23:16] = RxData;
            default: begin
              len_d = len_full;
              if ({1'b0, len_full} > MAX_N) state_d = S_ERR;
              else if (len_full == 32'd0)   state_d = S_CHK;
              else                          state_d = S_DATA;
            end
          endcase
        end
      end

      S_DATA: begin
        if (RxValid) begin
          chk_d      = chk_q ^ RxData;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = RxData;
            2'd1: asm_d[15:8]  = RxData;
            2'd2: asm_d[23:16] = RxData;
            default: begin
              we_d       = 1'b1;
              waddr_d    = word_idx_q[ADDR_W-1:0];
              wdata_d    = {RxData, asm_q};
              word_idx_d = word_idx_q + 1'b1;
              if (words_written == len_q) state_d = S_CHK;
            end
          endcase
        end
      end

      S_CHK: begin
        if (RxValid) state_d = (RxData == chk_q) ? S_DONE : S_ERR;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign WE      = we_q;
  assign WAddr   = waddr_q;
  assign WData   = wdata_q;
  assign CpuRstN = cpu_rst_n_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Error   = error_q;

endmodule
